// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 scan driver.
// Holds the scan FSM state type, the frame RAM geometry (address and data
// widths) and the bit position of each colour channel inside one plane of a
// frame RAM word. A word carries all planes: bit (plane*12 + ch).
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DISPLAY  = 3'd4,
        ST_GUARD    = 3'd5
    } scan_state_e;

    localparam int CH_PER_PLANE = 12;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 48;
    localparam int SEL_W        = $clog2(DATA_W);

    localparam int CH_R0 = 0;
    localparam int CH_G0 = 1;
    localparam int CH_B0 = 2;
    localparam int CH_R1 = 3;
    localparam int CH_G1 = 4;
    localparam int CH_B1 = 5;
    localparam int CH_R2 = 6;
    localparam int CH_G2 = 7;
    localparam int CH_B2 = 8;
    localparam int CH_R3 = 9;
    localparam int CH_G3 = 10;
    localparam int CH_B3 = 11;

    // Larger of two integers, used to size counters at elaboration time.
    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing the DISPLAY and GUARD intervals.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_start      load i_load_val and begin counting (wins over a running count)
//   i_load_val   interval length in cycles (must be >= 1)
//   o_done       high during the last cycle of the interval
// After a start, o_done rises exactly i_load_val cycles later counting the
// first cycle of the interval as cycle 1, so a load of N gives N cycles.
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int CNT_W = 10
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    // Count register: loads N-1 so that the zero cycle is the Nth one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= i_load_val - CNT_W'(1);
            r_run <= 1'b1;
        end else if (r_run && (r_cnt == {CNT_W{1'b0}})) begin
            r_run <= 1'b0;
        end else if (r_run) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
            r_run <= r_run;
        end
    end

    assign o_done = r_run && (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/hub75_scan_driver.sv
// HUB75 RGB matrix scan driver with 4-plane binary-coded modulation.
// Reads colour words from the frame RAM (read-only port), shifts one row of
// COLS columns per plane, latches it, then lights the row for BASE_TIME<<plane
// cycles followed by a GUARD_CYC blanked gap.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              scanning runs while high (sampled in IDLE and at plane end)
//   mem_address         frame RAM word address = row*COLS + col
//   mem_clk             RAM clock (same as clk)
//   mem_write_enable    always 0
//   mem_output_data     RAM data, valid one cycle after mem_address
//   r0..b3              colour pins for the current column
//   a                   row address shown on the panel
//   blank               1 = LEDs off
//   sclk                shift clock, panel samples on the rising edge
//   latch               one-cycle latch pulse
//   frame_done          one-cycle pulse once every full frame
// All panel-facing outputs are registered; they are computed from the state
// the FSM is entering, so they line up exactly with the state they belong to.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS      = 128,
    parameter int ROWS      = 8,
    parameter int PLANES    = 4,
    parameter int BASE_TIME = 64,
    parameter int GUARD_CYC = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_clk,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_output_data,
    output logic              r0,
    output logic              g0,
    output logic              b0,
    output logic              r1,
    output logic              g1,
    output logic              b1,
    output logic              r2,
    output logic              g2,
    output logic              b2,
    output logic              r3,
    output logic              g3,
    output logic              b3,
    output logic [2:0]        a,
    output logic              blank,
    output logic              sclk,
    output logic              latch,
    output logic              frame_done
);

    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PL_W     = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int MAX_DISP = BASE_TIME << (PLANES - 1);
    localparam int CNT_W    = $clog2(max_int(MAX_DISP, GUARD_CYC)) + 1;

    scan_state_e              r_state;
    logic [2:0]               r_row;
    logic [PL_W-1:0]          r_plane;
    logic [COL_W-1:0]         r_col;
    logic                     r_phase;
    logic [ADDR_W-1:0]        r_addr;
    logic [CH_PER_PLANE-1:0]  r_rgb;
    logic [2:0]               r_a;
    logic                     r_blank;
    logic                     r_sclk;
    logic                     r_latch;
    logic                     r_frame_done;

    scan_state_e              w_state_nxt;
    logic [2:0]               w_row_nxt;
    logic [PL_W-1:0]          w_plane_nxt;
    logic [COL_W-1:0]         w_col_nxt;
    logic                     w_phase_nxt;
    logic [ADDR_W-1:0]        w_addr_nxt;
    logic [CH_PER_PLANE-1:0]  w_rgb_nxt;
    logic [2:0]               w_a_nxt;
    logic                     w_blank_nxt;
    logic                     w_sclk_nxt;
    logic                     w_latch_nxt;
    logic                     w_frame_done_nxt;
    logic                     w_tmr_start;
    logic [CNT_W-1:0]         w_tmr_load;
    logic                     w_tmr_done;
    logic [SEL_W-1:0]         w_slice_base;

    // Frame RAM word address of a given row and column.
    function automatic logic [ADDR_W-1:0] word_addr(input int row, input int col);
        return ADDR_W'(row * COLS + col);
    endfunction

    assign w_slice_base = SEL_W'(int'(r_plane) * CH_PER_PLANE);

    hub75_bcm_timer #(
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_tmr_start),
        .i_load_val (w_tmr_load),
        .o_done     (w_tmr_done)
    );

    // Next-state and next-output logic of the scan sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_plane_nxt      = r_plane;
        w_col_nxt        = r_col;
        w_phase_nxt      = r_phase;
        w_addr_nxt       = r_addr;
        w_rgb_nxt        = r_rgb;
        w_a_nxt          = r_a;
        w_frame_done_nxt = 1'b0;
        w_tmr_start      = 1'b0;
        w_tmr_load       = {CNT_W{1'b0}};

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_PREFETCH;
                    w_addr_nxt  = word_addr(int'(r_row), 0);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PREFETCH: begin
                // Column 0 is being read now; queue column 1 for its phase 0.
                w_state_nxt = ST_SHIFT;
                w_col_nxt   = {COL_W{1'b0}};
                w_phase_nxt = 1'b0;
                w_addr_nxt  = word_addr(int'(r_row), (COLS > 1) ? 1 : 0);
            end
            ST_SHIFT: begin
                if (!r_phase) begin
                    w_rgb_nxt   = mem_output_data[w_slice_base +: CH_PER_PLANE];
                    w_phase_nxt = 1'b1;
                end else if (int'(r_col) == COLS - 1) begin
                    w_state_nxt = ST_LATCH;
                    w_phase_nxt = 1'b0;
                    w_a_nxt     = r_row;
                end else begin
                    // Entering phase 0 of col+1, which presents the address of col+2.
                    w_col_nxt   = r_col + COL_W'(1);
                    w_phase_nxt = 1'b0;
                    w_addr_nxt  = word_addr(int'(r_row),
                                            (int'(r_col) + 2 < COLS) ? int'(r_col) + 2 : COLS - 1);
                end
            end
            ST_LATCH: begin
                w_state_nxt = ST_DISPLAY;
                w_tmr_start = 1'b1;
                w_tmr_load  = CNT_W'(BASE_TIME << int'(r_plane));
            end
            ST_DISPLAY: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_GUARD;
                    w_tmr_start = 1'b1;
                    w_tmr_load  = CNT_W'(GUARD_CYC);
                end else begin
                    w_state_nxt = ST_DISPLAY;
                end
            end
            ST_GUARD: begin
                if (w_tmr_done) begin
                    if (int'(r_plane) == PLANES - 1) begin
                        w_plane_nxt = {PL_W{1'b0}};
                        if (int'(r_row) == ROWS - 1) begin
                            w_row_nxt        = 3'd0;
                            w_frame_done_nxt = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 3'd1;
                        end
                    end else begin
                        w_plane_nxt = r_plane + PL_W'(1);
                    end
                    if (enable) begin
                        w_state_nxt = ST_PREFETCH;
                        w_addr_nxt  = word_addr(int'(w_row_nxt), 0);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_GUARD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_blank_nxt = (w_state_nxt != ST_DISPLAY);
        w_sclk_nxt  = (w_state_nxt == ST_SHIFT) && w_phase_nxt;
        w_latch_nxt = (w_state_nxt == ST_LATCH);
    end

    // State, position and registered panel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_row        <= 3'd0;
            r_plane      <= {PL_W{1'b0}};
            r_col        <= {COL_W{1'b0}};
            r_phase      <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_rgb        <= {CH_PER_PLANE{1'b0}};
            r_a          <= 3'd0;
            r_blank      <= 1'b1;
            r_sclk       <= 1'b0;
            r_latch      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_plane      <= w_plane_nxt;
            r_col        <= w_col_nxt;
            r_phase      <= w_phase_nxt;
            r_addr       <= w_addr_nxt;
            r_rgb        <= w_rgb_nxt;
            r_a          <= w_a_nxt;
            r_blank      <= w_blank_nxt;
            r_sclk       <= w_sclk_nxt;
            r_latch      <= w_latch_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign mem_address      = r_addr;
    assign mem_clk          = clk;
    assign mem_write_enable = 1'b0;
    assign r0               = r_rgb[CH_R0];
    assign g0               = r_rgb[CH_G0];
    assign b0               = r_rgb[CH_B0];
    assign r1               = r_rgb[CH_R1];
    assign g1               = r_rgb[CH_G1];
    assign b1               = r_rgb[CH_B1];
    assign r2               = r_rgb[CH_R2];
    assign g2               = r_rgb[CH_G2];
    assign b2               = r_rgb[CH_B2];
    assign r3               = r_rgb[CH_R3];
    assign g3               = r_rgb[CH_G3];
    assign b3               = r_rgb[CH_B3];
    assign a                = r_a;
    assign blank            = r_blank;
    assign sclk             = r_sclk;
    assign latch            = r_latch;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Self-checking bench for hub75_scan_driver in a small configuration
// (COLS=4, ROWS=8, PLANES=4, BASE_TIME=2, GUARD_CYC=1).
// A protocol-level reference model follows the scan position (row, plane,
// column) from the panel's point of view and checks every sclk rising edge,
// latch pulse, lit interval and frame_done pulse against the frame RAM.
module tb_hub75_scan_driver;

    localparam int COLS      = 4;
    localparam int ROWS      = 8;
    localparam int PLANES    = 4;
    localparam int BASE_TIME = 2;
    localparam int GUARD_CYC = 1;
    localparam int FRAME_CYC = 592;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [9:0]  mem_address;
    logic        mem_clk;
    logic        mem_write_enable;
    logic [47:0] mem_output_data;
    logic        r0, g0, b0, r1, g1, b1, r2, g2, b2, r3, g3, b3;
    logic [2:0]  a;
    logic        blank, sclk, latch, frame_done;

    logic [47:0] ram [0:1023];

    int checks   = 0;
    int failures = 0;

    hub75_scan_driver #(
        .COLS(COLS), .ROWS(ROWS), .PLANES(PLANES),
        .BASE_TIME(BASE_TIME), .GUARD_CYC(GUARD_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .mem_address(mem_address), .mem_clk(mem_clk),
        .mem_write_enable(mem_write_enable), .mem_output_data(mem_output_data),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .r2(r2), .g2(g2), .b2(b2), .r3(r3), .g3(g3), .b3(b3),
        .a(a), .blank(blank), .sclk(sclk), .latch(latch), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read frame RAM: data follows the address by one cycle.
    always @(posedge clk) mem_output_data <= ram[mem_address];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] pins();
        return {b3, g3, r3, b2, g2, r2, b1, g1, r1, b0, g0, r0};
    endfunction

    // ---------------- reference model state ----------------
    int m_row, m_plane, m_col, run_len, edge_ord;
    int edges_total, latches_total, hits, hit_ord;
    logic [11:0] hit_bits;
    int wrap_pending, since_rise, cyc;
    int fd_times[$];
    int fd_edges[$];
    logic prev_sclk, prev_blank;
    logic [2:0] prev_a;

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_row = 0; m_plane = 0; m_col = 0; run_len = 0; edge_ord = 0;
                edges_total = 0; latches_total = 0; hits = 0; hit_ord = -1; hit_bits = 12'h000;
                wrap_pending = 0; since_rise = 0;
                fd_times.delete(); fd_edges.delete();
                prev_sclk = 1'b0; prev_blank = 1'b1; prev_a = 3'd0;
            end else begin
                if (sclk && !prev_sclk) begin
                    logic [47:0] w;
                    w = ram[m_row * COLS + m_col];
                    chk("colour_at_edge", pins(), w[m_plane*12 +: 12]);
                    chk("addr_at_edge", mem_address,
                        m_row * COLS + ((m_col + 1 < COLS) ? m_col + 1 : COLS - 1));
                    chk("blank_during_shift", blank, 1'b1);
                    if (pins() != 12'h000) begin
                        hits++; hit_ord = edge_ord; hit_bits = pins();
                    end
                    m_col++; edge_ord++; edges_total++;
                end
                if (latch) begin
                    chk("cols_before_latch", m_col, COLS);
                    chk("a_at_latch", a, m_row);
                    m_col = 0;
                    latches_total++;
                end
                if (a != prev_a) chk("a_change_in_blanked_latch", {latch, blank}, 2'b11);
                if (!blank) begin
                    run_len++;
                end else if (!prev_blank) begin
                    chk("display_len", run_len, BASE_TIME << m_plane);
                    run_len = 0;
                    m_plane++;
                    if (m_plane == PLANES) begin
                        m_plane = 0;
                        m_row++;
                        if (m_row == ROWS) begin
                            m_row = 0; wrap_pending = 1; since_rise = 0; edge_ord = 0;
                        end
                    end
                end
                if (frame_done) begin
                    chk("frame_done_expected", wrap_pending, 1);
                    wrap_pending = 0;
                    fd_times.push_back(cyc);
                    fd_edges.push_back(edges_total);
                end else if (wrap_pending != 0 && since_rise >= GUARD_CYC + 1) begin
                    chk("frame_done_window", frame_done, 1'b1);
                    wrap_pending = 0;
                end
                if (wrap_pending != 0) since_rise++;
                prev_sclk = sclk; prev_blank = blank; prev_a = a;
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_pos(input int row, input int plane, input int mincol,
                            input int budget, input string name);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if ((row < 0 || m_row == row) && m_plane == plane && m_col >= mincol) begin
                found = 1;
                break;
            end
        end
        chk(name, found, 1);
    endtask

    task automatic wait_latches(input int n, input int budget, input string name);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (latches_total >= n) begin found = 1; break; end
        end
        chk(name, found, 1);
    endtask

    task automatic wait_fd(input int n, input int budget, input string name);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (fd_times.size() >= n) begin found = 1; break; end
        end
        chk(name, found, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          row;
        int          col;
        int          plane;
        int          ch;
        int          exp_ord;
        logic [11:0] exp_bits;
    } pix_vec_t;

    pix_vec_t vecs [5];

    initial begin
        int snap_e, snap_l, found;

        vecs[0] = '{row: 2, col: 1, plane: 3, ch: 3,  exp_ord: 45,  exp_bits: 12'h008};
        vecs[1] = '{row: 0, col: 0, plane: 0, ch: 0,  exp_ord: 0,   exp_bits: 12'h001};
        vecs[2] = '{row: 7, col: 3, plane: 3, ch: 11, exp_ord: 127, exp_bits: 12'h800};
        vecs[3] = '{row: 5, col: 2, plane: 1, ch: 7,  exp_ord: 86,  exp_bits: 12'h080};
        vecs[4] = '{row: 3, col: 0, plane: 2, ch: 4,  exp_ord: 56,  exp_bits: 12'h010};

        for (int i = 0; i < 1024; i++) ram[i] = 48'h0;

        // Reset held with enable high: nothing may move.
        rst_n = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rst_blank", blank, 1'b1);
            chk("rst_sclk", sclk, 1'b0);
            chk("rst_latch", latch, 1'b0);
            chk("rst_a", a, 3'd0);
            chk("rst_addr", mem_address, 10'd0);
            chk("rst_frame_done", frame_done, 1'b0);
            chk("rst_colours", pins(), 12'h000);
            chk("mem_we", mem_write_enable, 1'b0);
        end

        // Word k = k replicated; one plane, then two full frames.
        for (int k = 0; k < ROWS * COLS; k++) begin
            logic [11:0] k12;
            k12 = 12'(k);
            ram[k] = {k12, k12, k12, k12};
        end
        #1 rst_n = 1'b1;
        wait_pos(0, 1, 0, 100, "first_plane_done");
        chk("plane0_edges", edges_total, 4);
        chk("plane0_latches", latches_total, 1);
        wait_fd(2, 2 * FRAME_CYC + 200, "two_frames");
        if (fd_times.size() >= 2) begin
            chk("frame_period", fd_times[1] - fd_times[0], FRAME_CYC);
            chk("edges_per_frame", fd_edges[1] - fd_edges[0], ROWS * PLANES * COLS);
        end

        // Single-bit pixels: exactly one lit edge at the right place.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < ROWS * COLS; i++) ram[i] = 48'h0;
            ram[vecs[v].row * COLS + vecs[v].col][vecs[v].plane * 12 + vecs[v].ch] = 1'b1;
            do_reset();
            wait_fd(1, FRAME_CYC + 100, "pix_frame");
            chk("pix_hits", hits, 1);
            chk("pix_edge_ord", hit_ord, vecs[v].exp_ord);
            chk("pix_bits", hit_bits, vecs[v].exp_bits);
        end

        // Random image; drop enable during SHIFT of row 1 plane 2.
        for (int i = 0; i < ROWS * COLS; i++) ram[i] = 48'({$urandom(), $urandom()});
        do_reset();
        wait_pos(1, 2, 1, 2 * FRAME_CYC, "reach_row1_plane2");
        enable = 1'b0;
        wait_pos(1, 3, 0, 100, "plane_completes");
        snap_e = edges_total;
        snap_l = latches_total;
        repeat (30) @(posedge clk);
        #1;
        chk("idle_no_edges", edges_total - snap_e, 0);
        chk("idle_no_latch", latches_total - snap_l, 0);
        chk("idle_blank", blank, 1'b1);
        chk("idle_sclk", sclk, 1'b0);
        enable = 1'b1;
        wait_latches(snap_l + 1, 50, "resume_latch");
        chk("resume_row", a, 3'd1);
        wait_pos(2, 0, 0, 100, "resume_plane3_done");
        chk("resume_edges", edges_total - snap_e, COLS);

        // Asynchronous reset in the middle of a lit interval.
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!blank) begin found = 1; break; end
        end
        chk("reach_display", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_blank", blank, 1'b1);
        chk("async_a", a, 3'd0);
        chk("async_addr", mem_address, 10'd0);
        chk("async_sclk_latch", {sclk, latch}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_latches(1, 40, "restart_latch");
        chk("restart_row", a, 3'd0);
        wait_pos(0, 1, 0, 60, "restart_plane0_done");
        chk("restart_edges", edges_total, COLS);
        wait_fd(1, FRAME_CYC + 100, "restart_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
